// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU (port A) and an
// external loader/debug/DMA master (port B). Round-robin, one access per cycle,
// reads return one cycle after the grant through per-port data registers.
// Optional feature macro: DMEM_ARB_LOCK_EN (lets port B hold the memory for up
// to LOCK_MAX consecutive grants while b_lock is asserted).
module dmem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          a_stall,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  input  logic          b_lock,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_memwrite,
  output logic          m_memread,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  port_e         last_reg, last_next;
  logic          gnt_a, gnt_b;
  logic          hold;      // port B owns the memory this cycle
  logic          lock_end;  // an ownership period finishes this cycle
  logic          a_rvalid_reg, b_rvalid_reg;
  logic [DW-1:0] a_rdata_reg, b_rdata_reg;

`ifdef DMEM_ARB_LOCK_EN
  localparam int CW = ($clog2(LOCK_MAX + 1) > 3) ? $clog2(LOCK_MAX + 1) : 3;
  localparam logic [CW-1:0] LAST_CNT = CW'(LOCK_MAX - 1);

  logic [CW-1:0] lock_cnt_reg, lock_cnt_next;
  logic          owned;

  assign owned    = (lock_cnt_reg != '0);
  assign hold     = owned & b_req & b_lock;
  assign lock_end = owned & ~hold;

  // Count grants inside a locked burst; the LOCK_MAX-th grant releases ownership,
  // so the counter is cleared at that edge instead of holding LOCK_MAX.
  always_comb begin
    lock_cnt_next = lock_cnt_reg;
    if (owned) begin
      if (!hold || lock_cnt_reg >= LAST_CNT) begin
        lock_cnt_next = '0;
      end else begin
        lock_cnt_next = lock_cnt_reg + CW'(1);
      end
    end else if (gnt_b && b_lock && (LOCK_MAX > 1)) begin
      lock_cnt_next = CW'(1);
    end
  end

  // Lock counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_reg <= '0;
    end else begin
      lock_cnt_reg <= lock_cnt_next;
    end
  end
`else
  logic unused_b_lock;
  assign unused_b_lock = b_lock;
  assign hold          = 1'b0;
  assign lock_end      = 1'b0;
`endif

  // Grant selection: lock ownership first, then round-robin against last winner.
  // Grants are forced low while reset is asserted so no strobe reaches memory.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (hold) begin
      gnt_b = 1'b1;
    end else if (a_req && b_req) begin
      if (last_reg == PORT_B) gnt_a = 1'b1;
      else                    gnt_b = 1'b1;
    end else if (a_req) begin
      gnt_a = 1'b1;
    end else if (b_req) begin
      gnt_b = 1'b1;
    end
    if (!rst_n) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end
  end

  // Memory-side mux: the granted port drives address, data and strobes; idle is all zero.
  always_comb begin
    m_addr     = '0;
    m_wdata    = '0;
    m_memwrite = 1'b0;
    m_memread  = 1'b0;
    if (gnt_a) begin
      m_addr     = a_addr;
      m_wdata    = a_wdata;
      m_memwrite = a_we;
      m_memread  = ~a_we;
    end else if (gnt_b) begin
      m_addr     = b_addr;
      m_wdata    = b_wdata;
      m_memwrite = b_we;
      m_memread  = ~b_we;
    end
  end

  // Last-winner update; the end of a lock period hands priority back to port A.
  always_comb begin
    last_next = last_reg;
    if (lock_end)   last_next = PORT_B;
    else if (gnt_a) last_next = PORT_A;
    else if (gnt_b) last_next = PORT_B;
  end

  // Round-robin state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= PORT_B;
    end else begin
      last_reg <= last_next;
    end
  end

  // Read return: capture memory data at the end of a read grant, valid for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_reg <= 1'b0;
      b_rvalid_reg <= 1'b0;
      a_rdata_reg  <= '0;
      b_rdata_reg  <= '0;
    end else begin
      a_rvalid_reg <= gnt_a & ~a_we;
      b_rvalid_reg <= gnt_b & ~b_we;
      if (gnt_a && !a_we) a_rdata_reg <= m_rdata;
      if (gnt_b && !b_we) b_rdata_reg <= m_rdata;
    end
  end

  assign a_gnt    = gnt_a;
  assign b_gnt    = gnt_b;
  assign a_stall  = a_req & ~gnt_a;
  assign a_rvalid = a_rvalid_reg;
  assign b_rvalid = b_rvalid_reg;
  assign a_rdata  = a_rdata_reg;
  assign b_rdata  = b_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a queue-based scoreboard. The stimulus
// task pushes the expected grant/strobe picture and expected read data; a monitor
// on the falling edge pops and compares whatever the DUT presents.
module tb_dmem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          a_gnt, a_rvalid, a_stall, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          m_memwrite, m_memread;

  dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_stall(a_stall),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_memwrite(m_memwrite), .m_memread(m_memread),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Data memory model: combinational read, write on the rising edge.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign m_rdata = mem[m_addr];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[16'h0010] = 32'hDEADBEEF;
    mem[16'h0014] = 32'hCAFEF00D;
    forever begin
      @(posedge clk);
      if (m_memwrite) mem[m_addr] <= m_wdata;
    end
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic          ea, eb, rd, wr;
    logic [AW-1:0] addr;
    string         tag;
  } gexp_t;
  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    string         tag;
  } rexp_t;

  gexp_t gq[$];
  rexp_t aq[$], bq[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issue one cycle of stimulus (called 1 time unit after a rising edge).
  task automatic step(input string tag,
                      input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input logic bl, input logic ea, input logic eb, input logic [DW-1:0] erd);
    gexp_t g;
    rexp_t r;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd; b_lock = bl;
    g.ea = ea; g.eb = eb;
    g.rd = (ea & ~aw) | (eb & ~bw);
    g.wr = (ea & aw) | (eb & bw);
    g.addr = ea ? aa : (eb ? ba : '0);
    g.tag = tag;
    gq.push_back(g);
    r.cyc = cyc_cnt + 1; r.data = erd; r.tag = tag;
    if (ea && !aw) aq.push_back(r);
    if (eb && !bw) bq.push_back(r);
    $display("[TB] %s cyc=%0d a_req=%0b b_req=%0b b_lock=%0b exp a_gnt=%0b b_gnt=%0b",
             tag, cyc_cnt, ar, br, bl, ea, eb);
    @(posedge clk); #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, 0, '0);
  endtask

  // Monitor: compares grant picture and read returns on every falling edge.
  gexp_t mg;
  rexp_t mr;
  always @(negedge clk) begin
    if (rst_n) begin
      if (gq.size() > 0) begin
        mg = gq.pop_front();
        chk({mg.tag, " a_gnt"},      a_gnt,      mg.ea);
        chk({mg.tag, " b_gnt"},      b_gnt,      mg.eb);
        chk({mg.tag, " a_stall"},    a_stall,    a_req & ~mg.ea);
        chk({mg.tag, " m_memread"},  m_memread,  mg.rd);
        chk({mg.tag, " m_memwrite"}, m_memwrite, mg.wr);
        chk({mg.tag, " m_addr"},     m_addr,     mg.addr);
      end
      if (aq.size() > 0 && aq[0].cyc == cyc_cnt) begin
        mr = aq.pop_front();
        chk({mr.tag, " a_rvalid"}, a_rvalid, 1'b1);
        chk({mr.tag, " a_rdata"},  a_rdata,  mr.data);
      end else if (a_rvalid) begin
        chk("unexpected a_rvalid", a_rvalid, 1'b0);
      end
      if (bq.size() > 0 && bq[0].cyc == cyc_cnt) begin
        mr = bq.pop_front();
        chk({mr.tag, " b_rvalid"}, b_rvalid, 1'b1);
        chk({mr.tag, " b_rdata"},  b_rdata,  mr.data);
      end else if (b_rvalid) begin
        chk("unexpected b_rvalid", b_rvalid, 1'b0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Grant patterns for contention runs, bit i = expected a_gnt in cycle i.
  logic [6:0] exp_a_seq;

  initial begin
    // Reset state while rst_n is held low
    #1;
    chk("reset a_rvalid", a_rvalid, 1'b0);
    chk("reset b_rvalid", b_rvalid, 1'b0);
    chk("reset a_rdata", a_rdata, 32'h0);
    chk("reset b_rdata", b_rdata, 32'h0);
    chk("reset a_gnt", a_gnt, 1'b0);
    chk("reset b_gnt", b_gnt, 1'b0);
    chk("reset m_memread", m_memread, 1'b0);
    chk("reset m_memwrite", m_memwrite, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // A read of 0x0010, then three idle cycles (the first one carries rvalid)
    step("t1 A rd 0x10", 1, 0, 16'h0010, '0, 0, 0, '0, '0, 0, 1, 0, 32'hDEADBEEF);
    idle("t6 idle0");
    idle("t6 idle1");
    idle("t6 idle2");

    // Fresh reset so last = B, then six cycles of full contention
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_a_seq = 7'b0010101;
    for (int i = 0; i < 6; i++) begin
      step($sformatf("t2 contend%0d", i), 1, 0, 16'h0010, '0, 1, 0, 16'h0014, '0, 0,
           exp_a_seq[i], ~exp_a_seq[i], exp_a_seq[i] ? 32'hDEADBEEF : 32'hCAFEF00D);
    end

    // B write to 0x0020, A reads it back on the next cycle
    step("t3 B wr 0x20", 0, 0, '0, '0, 1, 1, 16'h0020, 32'h12345678, 0, 0, 1, '0);
    step("t3 A rd 0x20", 1, 0, 16'h0020, '0, 0, 0, '0, '0, 0, 1, 0, 32'h12345678);

    // A write to 0x0030 granted, reset dropped before the edge that would commit it
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0030; a_wdata = 32'hA5A5A5A5;
    b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0;
    $display("[TB] t4 A wr 0x30 with reset mid-cycle cyc=%0d", cyc_cnt);
    @(negedge clk); #1;
    chk("t4 a_gnt before reset", a_gnt, 1'b1);
    chk("t4 m_memwrite before reset", m_memwrite, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t4 a_gnt in reset", a_gnt, 1'b0);
    chk("t4 m_memwrite in reset", m_memwrite, 1'b0);
    chk("t4 m_memread in reset", m_memread, 1'b0);
    chk("t4 a_rvalid in reset", a_rvalid, 1'b0);
    chk("t4 a_rdata in reset", a_rdata, 32'h0);
    chk("t4 b_rdata in reset", b_rdata, 32'h0);
    @(posedge clk); #1;
    a_req = 1'b0; a_we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t4 mem[0x30] unchanged", mem[16'h0030], 32'h0);

`ifdef DMEM_ARB_LOCK_EN
    // Locked burst: A first (last = B), B four times, A, then B again
    exp_a_seq = 7'b0100001;
    for (int i = 0; i < 7; i++) begin
      step($sformatf("t5 lock%0d", i), 1, 0, 16'h0010, '0, 1, 0, 16'h0014, '0, 1,
           exp_a_seq[i], ~exp_a_seq[i], exp_a_seq[i] ? 32'hDEADBEEF : 32'hCAFEF00D);
    end
`else
    // Without the lock feature b_lock has no effect: plain alternation
    exp_a_seq = 7'b1010101;
    for (int i = 0; i < 7; i++) begin
      step($sformatf("t5 nolock%0d", i), 1, 0, 16'h0010, '0, 1, 0, 16'h0014, '0, 1,
           exp_a_seq[i], ~exp_a_seq[i], exp_a_seq[i] ? 32'hDEADBEEF : 32'hCAFEF00D);
    end
`endif
    idle("drain0");
    idle("drain1");

    chk("a read queue drained", aq.size(), 0);
    chk("b read queue drained", bq.size(), 0);
    chk("grant queue drained", gq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory port (16-bit address, 32-bit data, memwrite/memread strobes) between two requesters.
- Port A is the CPU load/store path. Port B is the external loader/debug/DMA path.
- Arbitration is round-robin, one access per cycle, with registered read return.
- A CPU stall signal holds pc while port A waits for a grant.

Parameters:
- AW, 16, memory address width in bits.
- DW, 32, data width in bits.
- LOCK_MAX, 8, maximum consecutive cycles port B may hold the memory under lock. Used only with DMEM_ARB_LOCK_EN.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- a_req  input  1  port A access request
- a_we  input  1  port A write (1) / read (0)
- a_addr  input  AW  port A address
- a_wdata  input  DW  port A write data
- a_gnt  output  1  port A request accepted this cycle
- a_rvalid  output  1  port A read data valid
- a_rdata  output  DW  port A read data
- a_stall  output  1  a_req & ~a_gnt, to the pc update logic
- b_req, b_we, b_addr, b_wdata  inputs  1/1/AW/DW  port B, same meaning as port A
- b_lock  input  1  port B lock request; ignored without DMEM_ARB_LOCK_EN
- b_gnt, b_rvalid, b_rdata  outputs  1/1/DW  port B, same meaning as port A
- m_addr  output  AW  to data memory address
- m_wdata  output  DW  to data memory write data
- m_memwrite  output  1  to data memory write strobe
- m_memread  output  1  to data memory read strobe
- m_rdata  input  DW  from data memory, combinational read data

Behaviour:
- Reset (rst_n low, async) drives all of the following immediately:
  - a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0.
  - last = B, so port A wins the first conflict.
  - Lock counter = 0.
  - m_memwrite = m_memread = 0, gated combinationally while rst_n is low.
  - a_gnt = b_gnt = 0.
- Grant selection is combinational, once per cycle:
  - Only one request: grant it.
  - Both request: grant the port not equal to last.
  - No request: no grant, m_memread = m_memwrite = 0, m_addr/m_wdata = 0.
- Granted cycle N:
  - m_addr/m_wdata come from the granted port.
  - m_memwrite = we, m_memread = ~we.
  - The gnt pulse lasts exactly cycle N.
  - last updates to the granted port at the end of N.
- Write: commits in the data memory at the rising edge ending cycle N. No rvalid is generated.
- Read latency is exactly 1 cycle:
  - m_rdata is registered into x_rdata at the edge ending N.
  - x_rvalid = 1 for cycle N+1 only.
  - x_rdata holds its value until the next read completes for that port.
- Back-to-back grants to the same port are allowed when the other port is idle (full throughput, one access per cycle).
- Requests are level-sensitive. A requester keeps req and its fields stable until it sees gnt, then drops or changes them the next cycle.
- A refused requester is never lost. Under continuous contention the grants alternate A, B, A, B, so the maximum wait is 1 cycle.
- a_stall is combinational and equals a_req & ~a_gnt.
- Reset asserted mid-access: the in-flight write is suppressed if reset is low before the edge, and any pending rvalid is dropped.
- There is no FSM beyond last, the lock counter and the rvalid flops, so no illegal states exist.

Optional Feature:
DMEM_ARB_LOCK_EN
- Defined:
  - When b_gnt occurs with b_lock = 1, port B owns the memory; a 3-bit-or-wider counter starts at 1.
  - While owned and b_req & b_lock, B is granted every cycle regardless of last, and a_stall stays high.
  - Ownership ends when b_lock or b_req drops, or when the counter reaches LOCK_MAX.
  - When ownership ends, last = B and the counter is cleared.
  - A counter-forced release gives the next cycle to A if a_req = 1.
- Not defined: b_lock is ignored; pure round-robin applies.

Test Plan:
- Reset, then A read of addr 0x0010 with mem[0x0010] = 0xDEADBEEF → a_gnt in cycle 1, a_rvalid = 1 with a_rdata = 0xDEADBEEF in cycle 2, b_* outputs remain 0.
- A and B both request continuously for 6 cycles starting after reset → grant order A, B, A, B, A, B; a_stall is high only in the cycles where B is granted.
- B write 0x12345678 to 0x0020, then A read of 0x0020 in the next cycle → a_rdata = 0x12345678; no b_rvalid for the write.
- rst_n dropped during the cycle A is granted a write to 0x0030 (old value 0x0) → mem[0x0030] stays 0x0, all outputs return to their reset values asynchronously.
- DMEM_ARB_LOCK_EN with LOCK_MAX = 4, b_lock = b_req = 1 held and a_req = 1 → B granted 4 consecutive cycles, A granted in the 5th, then B again.
- Idle with no requests for 3 cycles → m_memread = m_memwrite = 0 and no gnt or rvalid pulses.
